// File: rtl/cbus_req_queue.sv
// cbus_req_queue: FIFO of CBUS requests issued one at a time to the memory top, one response each.
// Define CBUS_REQ_QUEUE_TIMEOUT_EN to abort requests that stay in ISSUE for TIMEOUT cycles.
module cbus_req_queue #(
  parameter int CBUS_AW = 9,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               sreset,
  input  logic               mst_valid,
  output logic               mst_ready,
  input  logic               mst_cmd,
  input  logic [CBUS_AW-1:0] mst_addr,
  input  logic [31:0]        mst_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_cmd,
  output logic [31:0]        rsp_rddata,
  output logic               rsp_err,
  output logic               cbus_req,
  output logic               cbus_slv_cmd,
  output logic [CBUS_AW-1:0] cbus_slv_address,
  output logic [31:0]        cbus_slv_wdata,
  input  logic               cbus_waccept,
  input  logic               cbus_rresp,
  input  logic [31:0]        cbus_rddata
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nxt;
  logic [CBUS_AW+32:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic push, pop, done, timeout, fin;
  assign mst_ready = count != (PW+1)'(DEPTH);
  assign push = mst_valid & mst_ready;
  assign pop = (state == IDLE) && (count != '0);
  // only the completion type matching the issued command counts
  assign done = (state == ISSUE) && (cbus_slv_cmd ? cbus_waccept : cbus_rresp);
  assign fin = done | timeout;
  assign cbus_req = state == ISSUE;
  assign rsp_valid = state == RESP;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE)  ? (pop ? ISSUE : IDLE) :
                (state == ISSUE) ? (fin ? RESP : ISSUE) :
                (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {mst_cmd, mst_addr, mst_wdata};
  always_ff @(posedge clk) begin
    if (sreset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      {cbus_slv_cmd, cbus_slv_address, cbus_slv_wdata} <= '0;
      rsp_cmd <= 1'b0;
      rsp_rddata <= '0;
    end else begin
      state <= state_nxt;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {cbus_slv_cmd, cbus_slv_address, cbus_slv_wdata} <= mem[rd_ptr];
      end
      if (state == ISSUE && fin) begin
        rsp_cmd <= cbus_slv_cmd;
        rsp_rddata <= (done && !cbus_slv_cmd) ? cbus_rddata : '0;
      end
    end
  end
`ifdef CBUS_REQ_QUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic err_q;
  // tcnt counts completed ISSUE cycles, so the abort lands at the end of cycle TIMEOUT
  assign timeout = (state == ISSUE) && (tcnt == TW'(TIMEOUT - 1));
  assign rsp_err = err_q;
  always_ff @(posedge clk) begin
    if (sreset) begin
      tcnt <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= pop ? '0 : (state == ISSUE) ? tcnt + 1'b1 : tcnt;
      if (state == ISSUE && fin) err_q <= !done;
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_cbus_req_queue.sv
// tb_cbus_req_queue: directed self-checking bench; timeout scenario runs when CBUS_REQ_QUEUE_TIMEOUT_EN is defined.
module tb_cbus_req_queue;
  logic clk = 0, sreset = 1, mst_valid = 0, mst_cmd = 0, rsp_ready = 0;
  logic cbus_waccept = 0, cbus_rresp = 0;
  logic [8:0] mst_addr = '0;
  logic [31:0] mst_wdata = '0, cbus_rddata = '0;
  logic mst_ready, rsp_valid, rsp_cmd, rsp_err, cbus_req, cbus_slv_cmd;
  logic [31:0] rsp_rddata, cbus_slv_wdata;
  logic [8:0] cbus_slv_address;
  int checks = 0, errors = 0;
  cbus_req_queue #(.CBUS_AW(9), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .sreset(sreset), .mst_valid(mst_valid), .mst_ready(mst_ready),
    .mst_cmd(mst_cmd), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cmd(rsp_cmd),
    .rsp_rddata(rsp_rddata), .rsp_err(rsp_err), .cbus_req(cbus_req),
    .cbus_slv_cmd(cbus_slv_cmd), .cbus_slv_address(cbus_slv_address),
    .cbus_slv_wdata(cbus_slv_wdata), .cbus_waccept(cbus_waccept),
    .cbus_rresp(cbus_rresp), .cbus_rddata(cbus_rddata));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic c, input logic [8:0] a, input logic [31:0] d);
    int n = 0;
    mst_valid = 1; mst_cmd = c; mst_addr = a; mst_wdata = d;
    while (mst_ready !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL push_wait got ready=%b exp 1 within 50 cycles", mst_ready); end
    tick();
    mst_valid = 0;
  endtask
  task automatic wait_req();
    int n = 0;
    while (cbus_req !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL req_wait got cbus_req=%b exp 1 within 50 cycles", cbus_req); end
  endtask
  task automatic ack();
    rsp_ready = 1; tick(); rsp_ready = 0;
  endtask
  task automatic test_reset();
    sreset = 1; tick(); tick();
    checks++;
    if ({mst_ready, rsp_valid, rsp_cmd, rsp_err, cbus_req, cbus_slv_cmd} !== 6'b100000) begin
      errors++; $display("FAIL reset_flags got %b exp 100000", {mst_ready, rsp_valid, rsp_cmd, rsp_err, cbus_req, cbus_slv_cmd});
    end
    checks++;
    if (rsp_rddata !== 32'h0) begin errors++; $display("FAIL reset_rddata got %h exp 0", rsp_rddata); end
    checks++;
    if (cbus_slv_address !== 9'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", cbus_slv_address); end
    checks++;
    if (cbus_slv_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", cbus_slv_wdata); end
    sreset = 0; tick();
  endtask
  task automatic test_write();
    int hc = 0;
    push(1, 9'h012, 32'hA5A5_5A5A);
    checks++;
    if (cbus_req !== 1'b0) begin errors++; $display("FAIL wr_latency got cbus_req=%b exp 0", cbus_req); end
    tick();
    for (int i = 0; i < 5; i++) begin
      if (cbus_req === 1'b1 && cbus_slv_cmd === 1'b1 && cbus_slv_address === 9'h012 && cbus_slv_wdata === 32'hA5A5_5A5A) hc++;
      if (i == 4) cbus_waccept = 1;
      tick();
    end
    cbus_waccept = 0;
    checks++;
    if (hc !== 5) begin errors++; $display("FAIL wr_req_cycles got %0d exp 5", hc); end
    checks++;
    if ({cbus_req, rsp_valid, rsp_cmd, rsp_err} !== 4'b0110) begin
      errors++; $display("FAIL wr_rsp got %b exp 0110", {cbus_req, rsp_valid, rsp_cmd, rsp_err});
    end
    checks++;
    if (rsp_rddata !== 32'h0) begin errors++; $display("FAIL wr_rddata got %h exp 0", rsp_rddata); end
    ack();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_drop got %b exp 0", rsp_valid); end
  endtask
  task automatic test_read();
    push(0, 9'h1FF, 32'h0);
    wait_req();
    checks++;
    if ({cbus_slv_cmd, cbus_slv_address} !== {1'b0, 9'h1FF}) begin
      errors++; $display("FAIL rd_issue got %b/%h exp 0/1ff", cbus_slv_cmd, cbus_slv_address);
    end
    cbus_waccept = 1; tick(); cbus_waccept = 0;
    checks++;
    if ({cbus_req, rsp_valid} !== 2'b10) begin errors++; $display("FAIL rd_wrong_pulse got %b exp 10", {cbus_req, rsp_valid}); end
    cbus_rresp = 1; cbus_rddata = 32'hDEAD_BEEF; tick(); cbus_rresp = 0; cbus_rddata = 0;
    checks++;
    if ({rsp_valid, rsp_cmd, rsp_err} !== 3'b100 || rsp_rddata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_rsp got %b %h exp 100 deadbeef", {rsp_valid, rsp_cmd, rsp_err}, rsp_rddata);
    end
    ack();
  endtask
  task automatic test_fill();
    for (int i = 0; i < 5; i++) push(1, 9'(i), 32'(i + 100));
    checks++;
    if (mst_ready !== 1'b0) begin errors++; $display("FAIL fill_full got ready=%b exp 0", mst_ready); end
    for (int i = 0; i < 5; i++) begin
      wait_req();
      checks++;
      if (cbus_slv_address !== 9'(i) || cbus_slv_wdata !== 32'(i + 100) || mst_ready !== (i != 0)) begin
        errors++; $display("FAIL fill_order%0d got addr=%h wdata=%0d ready=%b exp %h %0d %b",
                           i, cbus_slv_address, cbus_slv_wdata, mst_ready, 9'(i), i + 100, i != 0);
      end
      cbus_waccept = 1; tick(); cbus_waccept = 0;
      checks++;
      if ({rsp_valid, rsp_cmd} !== 2'b11) begin errors++; $display("FAIL fill_rsp%0d got %b exp 11", i, {rsp_valid, rsp_cmd}); end
      ack();
    end
  endtask
  task automatic test_stall();
    push(0, 9'h055, 32'h0);
    push(1, 9'h066, 32'h1111_2222);
    wait_req();
    checks++;
    if (cbus_slv_address !== 9'h055) begin errors++; $display("FAIL stall_issue got %h exp 055", cbus_slv_address); end
    cbus_rresp = 1; cbus_rddata = 32'h1234_5678; tick(); cbus_rresp = 0; cbus_rddata = 0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, cbus_req, rsp_cmd, rsp_err} !== 4'b1000 || rsp_rddata !== 32'h1234_5678) begin
        errors++; $display("FAIL stall_hold%0d got %b %h exp 1000 12345678", i, {rsp_valid, cbus_req, rsp_cmd, rsp_err}, rsp_rddata);
      end
      tick();
    end
    ack();
    wait_req();
    checks++;
    if ({cbus_slv_cmd, cbus_slv_address} !== {1'b1, 9'h066}) begin
      errors++; $display("FAIL stall_next got %b/%h exp 1/066", cbus_slv_cmd, cbus_slv_address);
    end
    cbus_waccept = 1; tick(); cbus_waccept = 0;
    ack();
  endtask
`ifdef CBUS_REQ_QUEUE_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    push(0, 9'h010, 32'h0);
    push(0, 9'h020, 32'h0);
    wait_req();
    while (cbus_req === 1'b1 && n < 20) begin n++; tick(); end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL to_cycles got %0d exp 8", n); end
    checks++;
    if ({rsp_valid, rsp_cmd, rsp_err} !== 3'b101 || rsp_rddata !== 32'h0) begin
      errors++; $display("FAIL to_rsp got %b %h exp 101 0", {rsp_valid, rsp_cmd, rsp_err}, rsp_rddata);
    end
    ack();
    wait_req();
    checks++;
    if (cbus_slv_address !== 9'h020) begin errors++; $display("FAIL to_next got %h exp 020", cbus_slv_address); end
    for (int i = 1; i < 8; i++) tick();
    cbus_rresp = 1; cbus_rddata = 32'hCAFE_F00D; tick(); cbus_rresp = 0; cbus_rddata = 0;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rddata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL to_race got %b %h exp 10 cafef00d", {rsp_valid, rsp_err}, rsp_rddata);
    end
    ack();
  endtask
`endif
  task automatic test_reset_mid();
    int stale = 0;
    push(1, 9'h001, 32'h1);
    push(1, 9'h002, 32'h2);
    push(1, 9'h003, 32'h3);
    wait_req();
    sreset = 1; tick();
    checks++;
    if ({cbus_req, rsp_valid, mst_ready} !== 3'b001) begin
      errors++; $display("FAIL rst_mid got %b exp 001", {cbus_req, rsp_valid, mst_ready});
    end
    sreset = 0; cbus_waccept = 1; cbus_rresp = 1;
    for (int i = 0; i < 10; i++) begin
      if (cbus_req !== 1'b0 || rsp_valid !== 1'b0) stale++;
      tick();
    end
    cbus_waccept = 0; cbus_rresp = 0;
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL rst_stale got %0d exp 0", stale); end
    push(0, 9'h0AA, 32'h0);
    wait_req();
    checks++;
    if ({cbus_slv_cmd, cbus_slv_address} !== {1'b0, 9'h0AA}) begin
      errors++; $display("FAIL rst_after got %b/%h exp 0/0aa", cbus_slv_cmd, cbus_slv_address);
    end
    cbus_rresp = 1; tick(); cbus_rresp = 0;
    ack();
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_fill();
    test_stall();
`ifdef CBUS_REQ_QUEUE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
